dcache_miss_ctrl: RTL
=====================

Name: dcache_miss_ctrl

Overview:
Blocking controller between the load/store unit and the 2-way, 4-set, 64-bit-line data cache lookup array.
- Sends each CPU access to the cache lookup port.
- On a load miss, fetches the aligned 64-bit word from memory and drives the cache refill port.
- Stores are write-through, no-allocate: they invalidate the cache set and go to memory.
- Allows one outstanding access. Keeps hit/miss performance counters.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width (equals the cache line width).
- UNCACHED_BASE, 64'hA000_0000. Addresses >= this value bypass the cache (MMIO): no lookup hit is used and no refill occurs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_wdata  in  64  store data
- req_wmask  in  8  store byte mask
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  64  load data (aligned 64-bit word)
- cache_raddr  out  64  cache lookup address
- cache_hit  in  1  combinational hit from the cache
- cache_rdata  in  64  combinational hit data
- cache_fill_en  out  1  refill write strobe
- cache_fill_addr  out  64  refill address, 8-byte aligned
- cache_fill_data  out  64  refill data
- cache_inv_en  out  1  store-invalidate strobe
- cache_inv_addr  out  64  store address
- cache_inv_data  out  64  store data
- cache_inv_mask  out  8  store mask
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts the request
- mem_we  out  1  memory write
- mem_addr  out  64  memory address
- mem_wdata  out  64  memory write data
- mem_wmask  out  8  memory write mask
- mem_resp_valid  in  1  memory response/ack pulse
- mem_rdata  in  64  memory read data
- perf_hits  out  64  count of cached loads that hit
- perf_misses  out  64  count of cached loads that missed

Behaviour:
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP.
- req_ready = (state == IDLE). The request is accepted when req_valid && req_ready; addr, we, wdata and wmask are latched into r_*.
- cache_raddr = r_addr at all times. Cacheable = r_addr < UNCACHED_BASE, compared unsigned over the full 64 bits.
- LOOKUP (exactly 1 cycle):
  - cacheable load with cache_hit: latch cache_rdata, perf_hits += 1, go to RESP.
  - cacheable load without cache_hit: perf_misses += 1, go to MEM_REQ.
  - uncacheable load: go to MEM_REQ; counters unchanged.
  - store: pulse cache_inv_en for this cycle with r_addr/r_wdata/r_wmask, regardless of cacheability; go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid = 1; mem_addr, mem_we, mem_wdata and mem_wmask are held stable until mem_req_ready.
  - Load: mem_addr = {r_addr[63:3], 3'b000}, mem_we = 0, mem_wmask = 8'hFF.
  - Store: mem_addr = r_addr, mem_we = 1, mem_wdata = r_wdata, mem_wmask = r_wmask.
  - On mem_req_ready go to MEM_WAIT. If mem_resp_valid arrives in the same cycle as mem_req_ready, handle it as in MEM_WAIT in that cycle.
- MEM_WAIT:
  - Wait for mem_resp_valid; there is no timeout.
  - Load: latch mem_rdata into the response register.
  - Cacheable load: additionally pulse cache_fill_en for that cycle with cache_fill_addr = aligned r_addr and cache_fill_data = mem_rdata.
  - Then go to RESP.
- RESP: resp_valid = 1 for exactly one cycle. resp_rdata = latched data for loads, 0 for stores. Go to IDLE. There is no CPU back-pressure on responses.
- Latency, with acceptance at cycle T:
  - load hit: resp_valid at T+2.
  - miss or store: resp_valid 1 cycle after the mem_resp_valid cycle.
- Counters are 64-bit and wrap modulo 2^64 silently.
- The strobes cache_fill_en and cache_inv_en are never high in the same cycle.
- mem_resp_valid outside MEM_REQ/MEM_WAIT is ignored.
- Reset:
  - state = IDLE; all r_* registers and resp_rdata = 0; perf counters = 0.
  - All valid and strobe outputs are 0 in the cycle after rst is sampled. req_ready = 1 after reset.
  - Reset mid-operation abandons the access: no resp_valid and no fill. A late mem_resp_valid after reset is ignored.
- Addresses in the range [UNCACHED_BASE-8, UNCACHED_BASE) are cacheable.

Decomposition:
- Shared package dcache_pkg:
  - state enum (IDLE = 0, LOOKUP = 1, MEM_REQ = 2, MEM_WAIT = 3, RESP = 4)
  - UNCACHED_BASE default
  - align8 constant mask 64'hFFFF_FFFF_FFFF_FFF8
- One sub-module, dcache_perf_cnt: two 64-bit counters with inc_hit/inc_miss inputs and synchronous reset.
- The FSM and datapath stay in dcache_miss_ctrl.

Test Plan:
- Load hit at 0x8000_0010 (cache_hit = 1, cache_rdata = 0x1122334455667788) -> resp_valid at T+2 with that data, no mem_req_valid, perf_hits = 1.
- Load miss at 0x8000_001C -> mem_addr = 0x8000_0018, mem_we = 0. mem_rdata = 0xDEADBEEF00000000 -> cache_fill_en one cycle, fill_addr = 0x8000_0018; resp next cycle with that data; perf_misses = 1.
- Store 0x8000_0008, wdata 0xAB, mask 0x01 -> cache_inv_en in LOOKUP; mem_we = 1, mem_wmask = 0x01. mem_req_ready held low 3 cycles -> request signals stable; resp_valid after ack with rdata = 0.
- Uncached load at 0xA000_0048 with cache_hit forced 1 -> memory read at 0xA000_0048, no fill, counters unchanged.
- mem_req_ready and mem_resp_valid high in the same cycle -> single-cycle MEM_REQ, response next cycle.
- rst asserted in MEM_WAIT, then mem_resp_valid -> no resp_valid, no fill; req_ready = 1; counters = 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache miss controller.
package dcache_pkg;

    localparam int unsigned PERF_W = 64;

    // Controller states; encoding is fixed so waveforms stay readable.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        RESP     = 3'd4
    } state_e;

    // Start of the MMIO window; everything at or above bypasses the cache.
    localparam logic [63:0] UNCACHED_BASE_DEF = 64'hA000_0000;

    // Clears the byte offset inside a 64-bit line.
    localparam logic [63:0] ALIGN8_MASK = 64'hFFFF_FFFF_FFFF_FFF8;

endpackage

// File: rtl/dcache_perf_cnt.sv
// Hit/miss performance counters; wrap silently modulo 2^PERF_W.
module dcache_perf_cnt
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_hit,
    input  logic              inc_miss,
    output logic [PERF_W-1:0] hits,
    output logic [PERF_W-1:0] misses
);

    // Independent counters, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hits   <= '0;
            misses <= '0;
        end else begin
            if (inc_hit) begin
                hits <= hits + PERF_W'(1);
            end
            if (inc_miss) begin
                misses <= misses + PERF_W'(1);
            end
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Blocking load/store controller in front of the data-cache lookup array.
// Loads look up the cache and refill on a miss; stores invalidate the set
// and write through to memory. One access is in flight at a time.
module dcache_miss_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 64,
    parameter int unsigned       DATA_W        = 64,
    parameter logic [ADDR_W-1:0] UNCACHED_BASE = ADDR_W'(UNCACHED_BASE_DEF)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,

    output logic [ADDR_W-1:0]   cache_raddr,
    input  logic                cache_hit,
    input  logic [DATA_W-1:0]   cache_rdata,
    output logic                cache_fill_en,
    output logic [ADDR_W-1:0]   cache_fill_addr,
    output logic [DATA_W-1:0]   cache_fill_data,
    output logic                cache_inv_en,
    output logic [ADDR_W-1:0]   cache_inv_addr,
    output logic [DATA_W-1:0]   cache_inv_data,
    output logic [DATA_W/8-1:0] cache_inv_mask,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic [PERF_W-1:0]   perf_hits,
    output logic [PERF_W-1:0]   perf_misses
);

    localparam int unsigned MASK_W = DATA_W / 8;

    state_e              state_q;
    state_e              state_d;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    logic                accept;
    logic                cacheable;
    logic [ADDR_W-1:0]   line_addr;
    logic                take_hit;
    logic                take_mem;
    logic                mem_done;
    logic                inc_hit;
    logic                inc_miss;

    assign accept    = req_valid && req_ready;
    assign cacheable = r_addr < UNCACHED_BASE;
    assign line_addr = r_addr & ADDR_W'(ALIGN8_MASK);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        cache_inv_en  = 1'b0;
        cache_fill_en = 1'b0;
        take_hit      = 1'b0;
        take_mem      = 1'b0;
        mem_done      = 1'b0;
        inc_hit       = 1'b0;
        inc_miss      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (r_we) begin
                    cache_inv_en = 1'b1;
                    state_d      = MEM_REQ;
                end else if (cacheable && cache_hit) begin
                    take_hit = 1'b1;
                    inc_hit  = 1'b1;
                    state_d  = RESP;
                end else begin
                    inc_miss = cacheable;
                    state_d  = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    // A response in the acceptance cycle completes immediately.
                    if (mem_resp_valid) begin
                        mem_done = 1'b1;
                        state_d  = RESP;
                    end else begin
                        state_d  = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_resp_valid) begin
                    mem_done = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mem_done && !r_we) begin
            take_mem      = 1'b1;
            cache_fill_en = cacheable;
        end
    end

    // Request capture and response data; stores respond with zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                r_we       <= req_we;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_wmask    <= req_wmask;
                resp_rdata <= '0;
            end
            if (take_hit) begin
                resp_rdata <= cache_rdata;
            end
            if (take_mem) begin
                resp_rdata <= mem_rdata;
            end
        end
    end

    // Cache and memory payloads come straight from the captured request.
    assign cache_raddr     = r_addr;
    assign cache_fill_addr = line_addr;
    assign cache_fill_data = mem_rdata;
    assign cache_inv_addr  = r_addr;
    assign cache_inv_data  = r_wdata;
    assign cache_inv_mask  = r_wmask;

    assign mem_we    = r_we;
    assign mem_addr  = r_we ? r_addr : line_addr;
    assign mem_wdata = r_we ? r_wdata : '0;
    assign mem_wmask = r_we ? r_wmask : '1;

    dcache_perf_cnt u_perf (
        .clk      (clk),
        .rst      (rst),
        .inc_hit  (inc_hit),
        .inc_miss (inc_miss),
        .hits     (perf_hits),
        .misses   (perf_misses)
    );

endmodule
